vec_mem_sequencer: RTL

Sequences one 256-bit vector memory access (vector load or store) as 8 consecutive 32-bit beats on the scalar data-memory port. It sits beside the Execute stage. While the transfer runs it holds the Decode/Execute pipeline register through a stall output, which the hazard unit ORs into StallE and the earlier-stage stalls. On completion it presents the assembled 256-bit read vector for the Memory stage.

---
 rtl/vec_seq_pkg.sv | 23 ++
 rtl/vec_seq_watchdog.sv | 46 ++++
 rtl/vec_mem_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vec_seq_pkg.sv
// ---------------------------------------------------------------------------
// vec_seq_pkg
// Shared types and constants for the vector memory sequencer.
//   state_t : sequencer FSM states (IDLE, XFER, DONE)
//   BEATS   : scalar beats per vector access for the default configuration
//   BEAT_W  : beat counter width
//   STRIDE  : byte stride between consecutive beats
// ---------------------------------------------------------------------------
package vec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int VEC_N  = 32;
    localparam int VEC_V  = 256;
    localparam int BEATS  = VEC_V / VEC_N;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int STRIDE = VEC_N / 8;

endpackage

// File: rtl/vec_seq_watchdog.sv
// ---------------------------------------------------------------------------
// vec_seq_watchdog
// Counts consecutive un-acknowledged beat cycles and flags a timeout so the
// sequencer can abort a transfer stuck on a dead memory port.
// Only instantiated when VEC_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   in_xfer in  sequencer is in XFER
//   ack     in  mem_ack for the current beat
//   timeout out abort request (combinational, valid in XFER only)
// ---------------------------------------------------------------------------
module vec_seq_watchdog
    import vec_seq_pkg::*;
#(
    parameter int TO_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic in_xfer,
    input  logic ack,
    output logic timeout
);

    localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

    logic [CW-1:0] wait_cnt;

    // Cleared whenever the beat is accepted or the sequencer is not in XFER,
    // so every beat gets a fresh budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!in_xfer || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // wait_cnt holds the number of earlier wait cycles; including the current
    // one the count reaches TO_CYCLES-1 here, giving TO_CYCLES-1 wait cycles
    // before the abort lands in DONE.
    assign timeout = in_xfer && !ack && (wait_cnt == CW'(TO_CYCLES - 2));

endmodule

// File: rtl/vec_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_mem_sequencer
// Breaks one V-bit vector load/store into V/N consecutive N-bit beats on the
// scalar data-memory port, stalling Decode/Execute while it runs and
// presenting the assembled load vector to the Memory stage.
// Optional feature: define VEC_SEQ_TIMEOUT_EN to add an ack watchdog that
// aborts a stalled transfer after TO_CYCLES-1 wait cycles and raises VecErr.
// Ports:
//   clk        in  clock (rising edge)
//   rst        in  asynchronous active-low reset
//   VecStartE  in  vector memory instruction present in Execute
//   VecWriteE  in  1 = store, 0 = load
//   VecAddrE   in  byte base address
//   VecWDataE  in  store vector
//   StallVec   out pipeline hold request
//   mem_req    out beat request
//   mem_we     out beat write enable
//   mem_addr   out beat byte address
//   mem_wdata  out beat write data
//   mem_ack    in  beat accepted (may be combinational from mem_req)
//   mem_rdata  in  beat read data
//   VecRDataM  out assembled load vector
//   VecDoneM   out one-cycle completion pulse
//   VecErr     out abort flag (with VecDoneM)
// ---------------------------------------------------------------------------
module vec_mem_sequencer
    import vec_seq_pkg::*;
#(
    parameter int N         = VEC_N,
    parameter int V         = VEC_V,
    parameter int TO_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         VecStartE,
    input  logic         VecWriteE,
    input  logic [N-1:0] VecAddrE,
    input  logic [V-1:0] VecWDataE,
    output logic         StallVec,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic [V-1:0] VecRDataM,
    output logic         VecDoneM,
    output logic         VecErr
);

    localparam int NBEATS = V / N;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int STR    = N / 8;

    if (((V % N) != 0) || (N < 8) || (TO_CYCLES < 2)) begin : g_bad_params
        $error("vec_mem_sequencer: illegal parameter combination");
    end

    state_t         state;
    logic [BW-1:0]  beat;
    logic [N-1:0]   base_q;
    logic           we_q;
    logic [V-1:0]   wdata_q;
    logic [V-1:0]   rbuf;
    logic           last_beat;

    assign last_beat = (beat == BW'(NBEATS - 1));

`ifdef VEC_SEQ_TIMEOUT_EN
    logic timeout;
    logic err_q;

    vec_seq_watchdog #(
        .TO_CYCLES (TO_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .in_xfer (state == XFER),
        .ack     (mem_ack),
        .timeout (timeout)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rbuf    <= '0;
`ifdef VEC_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (VecStartE) begin
                        base_q  <= VecAddrE;
                        we_q    <= VecWriteE;
                        wdata_q <= VecWDataE;
                        rbuf    <= '0;
                        beat    <= '0;
`ifdef VEC_SEQ_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            rbuf[beat*N +: N] <= mem_rdata;
                        end
                        beat <= beat + BW'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
`ifdef VEC_SEQ_TIMEOUT_EN
                    end else if (timeout) begin
                        // Unreceived beats stay 0 because rbuf was cleared at start.
                        err_q <= 1'b1;
                        state <= DONE;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All beat outputs decode from registered state only, so they hold
    // steady across wait cycles without extra holding registers.
    assign mem_req   = (state == XFER);
    assign mem_we    = (state == XFER) && we_q;
    assign mem_addr  = (state == XFER) ? (base_q + N'(beat) * N'(STR)) : '0;
    assign mem_wdata = (state == XFER) ? wdata_q[beat*N +: N] : '0;

    // Low in DONE so the Execute register advances on the DONE cycle edge.
    assign StallVec  = ((state == IDLE) && VecStartE) || (state == XFER);
    assign VecDoneM  = (state == DONE);
    assign VecRDataM = rbuf;

`ifdef VEC_SEQ_TIMEOUT_EN
    assign VecErr = (state == DONE) && err_q;
`else
    assign VecErr = 1'b0;
`endif

endmodule
